debug_step_controller: RTL and testbench
========================================

// Module: debug_step_controller
// PURPOSE
//   Host-side run/step/halt controller for the mips pipeline. It drives the pipeline's
//   i_stall input and services a byte-oriented debug command stream from the UART receiver.
//   It reads back register-file words and the PC as 4-byte replies to the UART transmitter.
//   It sits between the UART RX/TX bytes and the mips top: o_stall feeds mips.i_stall.
// PARAMETERS
//   SIZE        32     data word width (register / PC); reply is SIZE/8 bytes, MSB first
//   REG_ADDR_W  5      register-file debug address width
//   ACK_BYTE    8'h06  reply for accepted R/S/H commands
//   NAK_BYTE    8'h15  reply for unknown command byte
// PORTS
//   clk             in   1           system clock, all logic on rising edge
//   rst             in   1           synchronous, active-high reset
//   i_rx_data       in   8           command/argument byte from UART RX
//   i_rx_valid      in   1           1-cycle strobe, i_rx_data valid; no backpressure
//   o_tx_data       out  8           reply byte to UART TX
//   o_tx_valid      out  1           reply byte valid; held with stable data until accepted
//   i_tx_ready      in   1           TX accepts byte when o_tx_valid & i_tx_ready at clk edge
//   o_stall         out  1           to mips.i_stall; 1 = pipeline frozen
//   o_dbg_reg_addr  out  REG_ADDR_W  register index for debug read port
//   i_dbg_reg_data  in   SIZE        register-file read data (combinational from addr)
//   i_pc            in   SIZE        current PC from fetch stage
//   i_halt          in   1           pipeline fetched HALT instruction (level)
// BEHAVIOUR
//   - Reset: o_stall=1, o_tx_valid=0, o_tx_data=0, o_dbg_reg_addr=0, state=IDLE, byte cnt=0.
//   - All outputs are registered. Reset mid-operation aborts any reply or step; the partial reply is lost.
//   - States: IDLE (stalled), RUN, STEP, GET_ADDR, CAPTURE, SEND, REPLY1.
//   - Commands in IDLE, on i_rx_valid:
//     - 'R' 8'h52: o_stall->0 from the next cycle; queue ACK; go to RUN.
//     - 'S' 8'h53: go to STEP; o_stall=0 for exactly 1 cycle, then 1. ACK is presented in the
//       cycle o_stall returns to 1.
//     - 'H' 8'h48: queue ACK; stay stalled.
//     - 'G' 8'h47: go to GET_ADDR. The next rx byte's low REG_ADDR_W bits are registered into
//       o_dbg_reg_addr -> CAPTURE. One cycle later i_dbg_reg_data is latched into the shift
//       register -> SEND.
//     - 'P' 8'h50: latch i_pc into the shift register -> SEND.
//     - Any other byte: queue NAK.
//   - RUN: o_stall=0.
//     - 'H' byte -> o_stall=1 next cycle; ACK.
//     - i_halt=1 -> o_stall=1 next cycle; reply 8'h48 (autonomous halt notice).
//     - 'H' and i_halt in the same cycle: a single ACK only.
//     - Other bytes in RUN are ignored, with no reply.
//   - SEND: SIZE/8 bytes, MSB first. o_tx_data=shift[SIZE-1:SIZE-8].
//     - On each handshake: shift left 8, cnt+1. After the last byte -> IDLE.
//   - REPLY1 (single ACK/NAK/H): hold o_tx_valid until the handshake -> IDLE (or RUN after 'R').
//   - o_tx_valid drops in the cycle after the final handshake. o_tx_data is only meaningful while
//     o_tx_valid=1.
//   - rx bytes arriving during GET_ADDR use only the first byte. Bytes during CAPTURE, SEND,
//     REPLY1 or STEP are dropped, except 'H' while a RUN ACK is pending: o_stall->1, ACK still sent once.
//   - o_stall stays 1 in every state except RUN and the single STEP cycle.
//   - G and P are only legal while stalled, so the captured data is stable.
// TESTING
//   1 Reset: hold rst 2 cycles -> o_stall=1, o_tx_valid=0, o_dbg_reg_addr=0; no rx -> no tx.
//   2 Step: rx 8'h53 -> o_stall low exactly 1 cycle, then high; tx 8'h06 once, mips PC +4.
//   3 Reg read: rx 8'h47, 8'h03 with i_dbg_reg_data=32'hDEADBEEF, tx_ready stalling 2 cycles per byte
//     -> tx DE,AD,BE,EF in order, data held stable during stalls; o_dbg_reg_addr=3.
//   4 Run/halt: rx 8'h52 -> ACK, o_stall=0; raise i_halt -> o_stall=1 next cycle, tx 8'h48.
//     Repeat with 'H' byte and i_halt in the same cycle -> single 8'h06.
//   5 PC read + NAK: i_pc=32'h00000010, rx 8'h50 -> tx 00,00,00,10; rx 8'h7A -> tx 8'h15.
//   6 Reset mid-SEND: assert rst after 2nd byte of a G reply -> o_tx_valid=0 next cycle,
//     o_stall=1, next 'P' reply starts fresh at MSB.

Source files
------------

// File: rtl/debug_step_controller.sv
// Debug command front-end for the mips pipeline: run/step/halt control of the
// pipeline stall, plus register-file and PC readback as byte replies over UART.
module debug_step_controller #(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_stall,
    output logic [REG_ADDR_W-1:0] o_dbg_reg_addr,
    input  logic [SIZE-1:0]       i_dbg_reg_data,
    input  logic [SIZE-1:0]       i_pc,
    input  logic                  i_halt
);

    localparam int unsigned NBYTES = SIZE / 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_GET  = 8'h47;
    localparam logic [7:0] CMD_PC   = 8'h50;
    localparam logic [7:0] HALT_MSG = 8'h48;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STEP     = 3'd2,
        GET_ADDR = 3'd3,
        CAPTURE  = 3'd4,
        SEND     = 3'd5,
        REPLY1   = 3'd6
    } state_e;

    state_e                state_q, state_d;
    logic                  stall_q, stall_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Single-byte reply belongs to an 'R' command: return to RUN once it is sent.
    logic                  ret_run_q, ret_run_d;

    logic tx_fire;
    logic rx_h;

    assign tx_fire = tx_valid_q & i_tx_ready;
    assign rx_h    = i_rx_valid && (i_rx_data == CMD_HALT);

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stall_q    <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            addr_q     <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            ret_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ret_run_q  <= ret_run_d;
        end
    end

    // Command decode, stall control and reply sequencing.
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        ret_run_d  = ret_run_q;

        unique case (state_q)
            IDLE: begin
                stall_d = 1'b1;
                if (i_rx_valid) begin
                    unique case (i_rx_data)
                        CMD_RUN: begin
                            stall_d    = 1'b0;
                            tx_valid_d = 1'b1;
                            tx_data_d  = ACK_BYTE;
                            ret_run_d  = 1'b1;
                            state_d    = REPLY1;
                        end
                        CMD_STEP: begin
                            stall_d = 1'b0;
                            state_d = STEP;
                        end
                        CMD_HALT: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = ACK_BYTE;
                            ret_run_d  = 1'b0;
                            state_d    = REPLY1;
                        end
                        CMD_GET: begin
                            state_d = GET_ADDR;
                        end
                        CMD_PC: begin
                            shift_d    = i_pc;
                            tx_data_d  = i_pc[SIZE-1 -: 8];
                            tx_valid_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = SEND;
                        end
                        default: begin
                            tx_valid_d = 1'b1;
                            tx_data_d  = NAK_BYTE;
                            ret_run_d  = 1'b0;
                            state_d    = REPLY1;
                        end
                    endcase
                end
            end
            RUN: begin
                stall_d = 1'b0;
                // A host 'H' takes priority over the autonomous halt notice.
                if (rx_h || i_halt) begin
                    stall_d    = 1'b1;
                    tx_valid_d = 1'b1;
                    tx_data_d  = rx_h ? ACK_BYTE : HALT_MSG;
                    ret_run_d  = 1'b0;
                    state_d    = REPLY1;
                end
            end
            STEP: begin
                stall_d    = 1'b1;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_BYTE;
                ret_run_d  = 1'b0;
                state_d    = REPLY1;
            end
            GET_ADDR: begin
                if (i_rx_valid) begin
                    addr_d  = i_rx_data[REG_ADDR_W-1:0];
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                shift_d    = i_dbg_reg_data;
                tx_data_d  = i_dbg_reg_data[SIZE-1 -: 8];
                tx_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (tx_fire) begin
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        shift_d   = shift_q << 8;
                        tx_data_d = shift_q[SIZE-9 -: 8];
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            REPLY1: begin
                // 'H' while the RUN ACK is still pending freezes the pipeline at once.
                if (ret_run_q && rx_h) begin
                    stall_d   = 1'b1;
                    ret_run_d = 1'b0;
                end
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    ret_run_d  = 1'b0;
                    state_d    = (ret_run_q && !rx_h) ? RUN : IDLE;
                end
            end
            default: begin
                stall_d    = 1'b1;
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign o_stall        = stall_q;
    assign o_tx_valid     = tx_valid_q;
    assign o_tx_data      = tx_data_q;
    assign o_dbg_reg_addr = addr_q;

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed bench for debug_step_controller with a reply-byte scoreboard.
module tb_debug_step_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        stall;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] pc;
    logic        halt;

    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         mode  = 0;   // 0: ready always, 1: ready every third cycle, 2: never ready
    int         phase = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_d = 8'h00;

    always #5 clk = ~clk;

    // Register-file model: only r3 holds the pattern under test.
    assign dbg_data = (dbg_addr == 5'd3) ? 32'hDEADBEEF : (32'h0BAD0000 | 32'(dbg_addr));

    debug_step_controller dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_stall        (stall),
        .o_dbg_reg_addr (dbg_addr),
        .i_dbg_reg_data (dbg_data),
        .i_pc           (pc),
        .i_halt         (halt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // TX-side ready pattern.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: tx_ready = 1'b1;
            1: begin
                tx_ready = (phase == 2);
                phase = (phase == 2) ? 0 : phase + 1;
            end
            default: tx_ready = 1'b0;
        endcase
    end

    // Monitor: checks held data while stalled and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else if (tx_valid) begin
            if (held_v) chk("tx_hold", 32'(tx_data), 32'(held_d));
            if (tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got %h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = tx_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !tx_valid) return;
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        halt     = 1'b0;
        pc       = 32'h0;
        tx_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_addr", 32'(dbg_addr), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_tx", 32'(tx_valid), 32'd0);

        // Single step
        exp_q.push_back(8'h06);
        send_byte(8'h53);
        chk("step_stall_low", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("step_stall_back", 32'(stall), 32'd1);
        chk("step_ack_valid", 32'(tx_valid), 32'd1);
        @(posedge clk); #1;
        chk("step_stall_held", 32'(stall), 32'd1);
        wait_drain("step");

        // Register read with TX backpressure
        mode = 1;
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        send_byte(8'h47);
        send_byte(8'h03);
        wait_drain("reg_read");
        chk("reg_addr", 32'(dbg_addr), 32'd3);
        chk("reg_read_stall", 32'(stall), 32'd1);
        mode = 0;

        // Run then autonomous halt
        exp_q.push_back(8'h06);
        send_byte(8'h52);
        chk("run_stall_low", 32'(stall), 32'd0);
        wait_drain("run_ack");
        chk("run_stall_still_low", 32'(stall), 32'd0);
        @(posedge clk); #1;
        halt = 1'b1;
        exp_q.push_back(8'h48);
        @(posedge clk); #1;
        halt = 1'b0;
        chk("halt_stall", 32'(stall), 32'd1);
        wait_drain("halt_notice");
        chk("halt_idle_stall", 32'(stall), 32'd1);

        // Run then host 'H' coincident with i_halt: one ACK only
        exp_q.push_back(8'h06);
        send_byte(8'h52);
        wait_drain("run_ack2");
        exp_q.push_back(8'h06);
        @(posedge clk); #1;
        rx_data  = 8'h48;
        rx_valid = 1'b1;
        halt     = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        halt     = 1'b0;
        chk("h_halt_stall", 32'(stall), 32'd1);
        wait_drain("h_halt_ack");
        repeat (4) @(posedge clk);

        // 'H' while the RUN ACK is still pending
        mode = 2;
        exp_q.push_back(8'h06);
        send_byte(8'h52);
        chk("pend_run_stall", 32'(stall), 32'd0);
        send_byte(8'h48);
        chk("pend_h_stall", 32'(stall), 32'd1);
        mode = 0;
        wait_drain("pend_ack");
        repeat (3) @(posedge clk);
        #1;
        chk("pend_idle_stall", 32'(stall), 32'd1);

        // PC read and NAK
        pc = 32'h00000010;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        send_byte(8'h50);
        wait_drain("pc_read");
        exp_q.push_back(8'h15);
        send_byte(8'h7A);
        wait_drain("nak");

        // Reset after the second byte of a register reply
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
        send_byte(8'h47);
        send_byte(8'h03);
        begin
            int n;
            for (n = 0; n < 200; n++) begin
                @(negedge clk); #1;
                if (exp_q.size() == 0) break;
            end
            if (n == 200) begin
                tests++;
                fails++;
                $display("FAIL mid_send_timeout: got %0d bytes pending expected 0", exp_q.size());
            end
        end
        mode = 2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd1);
        rst  = 1'b0;
        mode = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        send_byte(8'h50);
        wait_drain("post_rst_pc");
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
